// File: rtl/pixel_stream_source_pkg.sv
// Shared frame-geometry defaults, per-cycle strobe bundle and counter sizing helper
// for the pixel stream source and its timing generator.
package pixel_stream_source_pkg;

  localparam int PIXEL_SIZE_DEF   = 24;
  localparam int FRAME_WIDTH_DEF  = 640;
  localparam int FRAME_HEIGHT_DEF = 480;
  localparam int H_BLANK_DEF      = 16;
  localparam int V_BLANK_DEF      = 4;
  localparam int ADDR_WIDTH_DEF   = 19;

  // Strobes travelling with each pixel slot through the alignment pipeline.
  typedef struct packed {
    logic en;
    logic hsync;
    logic vsync;
    logic done;
  } strobe_t;

  // Counter width for values 0..n-1; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_source_timing.sv
// Address-stage raster FSM: drives frame-memory reads and undelayed en/hsync/vsync/done.
// Zero latency from state; pause holds at the final blank cycle of a non-final line.
module pixel_source_timing
  import pixel_stream_source_pkg::*;
#(
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF,
  parameter int H_BLANK      = H_BLANK_DEF,
  parameter int V_BLANK      = V_BLANK_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic                  pause_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  busy_o,
  output strobe_t               strb_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBLANK = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;

  localparam int CW = cnt_w(FRAME_WIDTH);
  localparam int LW = cnt_w(FRAME_HEIGHT);
  localparam int BW = cnt_w((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);

  localparam logic [CW-1:0] COL_LAST  = CW'(FRAME_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [LW-1:0]         line_q, line_d;
  logic [BW-1:0]         blank_q, blank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    blank_d = blank_q;
    addr_d  = addr_q;
    hold_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        addr_d  = '0;
        col_d   = '0;
        line_d  = '0;
        blank_d = '0;
        state_d = (V_BLANK > 0) ? ST_VBLANK : ST_ACTIVE;
      end
      ST_VBLANK: begin
        if (blank_q == VB_LAST) begin
          blank_d = '0;
          state_d = ST_ACTIVE;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_ACTIVE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (col_q == COL_LAST) begin
          col_d   = '0;
          blank_d = '0;
          state_d = ST_HBLANK;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      ST_HBLANK: begin
        // Counter saturates on the final blank cycle so a pause hold stays there.
        if (blank_q != HB_LAST) begin
          blank_d = blank_q + BW'(1);
        end else if (line_q == LINE_LAST) begin
          blank_d = '0;
          state_d = continuous_i ? ST_VSYNC : ST_IDLE;
        end else if (pause_i) begin
          hold_d = 1'b1;
        end else begin
          blank_d = '0;
          line_d  = line_q + LW'(1);
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      blank_q <= '0;
      addr_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      blank_q <= blank_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign mem_rd_o   = (state_q == ST_ACTIVE);
  assign mem_addr_o = addr_q;

  // hold_q suppresses a repeated hsync when H_BLANK is 1 and the hold sits on blank 0.
  always_comb begin
    strb_o       = '0;
    strb_o.en    = (state_q == ST_ACTIVE);
    strb_o.vsync = (state_q == ST_VSYNC);
    strb_o.hsync = (state_q == ST_HBLANK) && (blank_q == '0) && !hold_q;
    strb_o.done  = strb_o.hsync && (line_q == LINE_LAST);
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Pixel stream transmitter: timing FSM plus 2-stage alignment (memory read, output regs).
// Outputs lag address-stage state by 2 cycles; pause holds only at line boundaries.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int PIXEL_SIZE   = PIXEL_SIZE_DEF,
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF,
  parameter int H_BLANK      = H_BLANK_DEF,
  parameter int V_BLANK      = V_BLANK_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  pause,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_rdata,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frame_count
);

  strobe_t               strb;
  strobe_t               s1_q, s2_q;
  logic [PIXEL_SIZE-1:0] data_q, data_d;
  logic [31:0]           frame_count_q, frame_count_d;

  pixel_source_timing #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .H_BLANK      (H_BLANK),
    .V_BLANK      (V_BLANK),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_timing (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .continuous_i (continuous),
    .pause_i      (pause),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .busy_o       (busy),
    .strb_o       (strb)
  );

  // mem_rdata is valid while s1_q describes the slot that issued the read.
  always_comb begin
    data_d        = s1_q.en ? mem_rdata : '0;
    frame_count_d = frame_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      data_q        <= '0;
      frame_count_q <= '0;
    end else begin
      s1_q   <= strb;
      s2_q   <= s1_q;
      data_q <= data_d;
      if (s1_q.done) begin
        frame_count_q <= frame_count_d;
      end
    end
  end

  assign en          = s2_q.en;
  assign hsync       = s2_q.hsync;
  assign vsync       = s2_q.vsync;
  assign done        = s2_q.done;
  assign data        = data_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source on a 4x2 frame (H_BLANK=2, V_BLANK=1, mem[i]=i+1).
module tb_pixel_stream_source;

  localparam int PS = 24;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int AW = 4;

  localparam logic [1:0] K_PIX = 2'd0;
  localparam logic [1:0] K_HS  = 2'd1;
  localparam logic [1:0] K_VS  = 2'd2;

  typedef struct packed {
    int          cyc;
    logic [1:0]  kind;
    logic [23:0] data;
    logic        done;
  } ev_t;

  logic          clk;
  logic          reset, start, continuous, pause;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [PS-1:0] mem_rdata;
  logic          en, hsync, vsync, busy, done;
  logic [PS-1:0] data;
  logic [31:0]   frame_count;

  pixel_stream_source #(
    .PIXEL_SIZE   (PS),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .H_BLANK      (HB),
    .V_BLANK      (VB),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .pause       (pause),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .data        (data),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PS-1:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = PS'(i + 1);
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[2:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [1:0] k, input int d, input logic dn);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = 24'(d); e.done = dn;
    exp_q.push_back(e);
  endtask

  // v = output cycle of vsync; pe = extra cycles the second line is delayed by a pause hold.
  task automatic push_frame(input int v, input int pe);
    push_ev(v, K_VS, 0, 1'b0);
    for (int k = 0; k < 4; k++) push_ev(v + 2 + k, K_PIX, k + 1, 1'b0);
    push_ev(v + 6, K_HS, 0, 1'b0);
    for (int k = 0; k < 4; k++) push_ev(v + 8 + pe + k, K_PIX, k + 5, 1'b0);
    push_ev(v + 12 + pe, K_HS, 0, 1'b1);
  endtask

  task automatic goto(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int x);
    goto(x);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 64'(en), 64'd0);
    chk({tag, "_hsync"}, 64'(hsync), 64'd0);
    chk({tag, "_vsync"}, 64'(vsync), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_data"}, 64'(data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
  endtask

  // Monitor: every presented event is popped and compared against the scoreboard.
  ev_t        mon_e;
  logic [1:0] mon_k;
  always @(negedge clk) begin
    if (!en) chk("data_zero_when_not_en", 64'(data), 64'd0);
    chk("en_exclusive_of_sync", 64'(en & (hsync | vsync)), 64'd0);
    if (en || hsync || vsync || done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event at cycle %0d: en=%0b hsync=%0b vsync=%0b done=%0b, expected no event",
                 cyc, en, hsync, vsync, done);
      end else begin
        mon_e = exp_q.pop_front();
        mon_k = vsync ? K_VS : (hsync ? K_HS : K_PIX);
        chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("event_kind", 64'(mon_k), 64'(mon_e.kind));
        chk("event_done", 64'(done), 64'(mon_e.done));
        if (mon_e.kind == K_PIX) chk("pixel_data", 64'(data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int b, b2;

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_state");

    // Single frame, continuous=0.
    goto(cyc + 2); b = cyc; start = 1'b1; push_frame(b + 3, 0);
    goto(b + 1); start = 1'b0;
    at_neg(b + 1);  chk("s1_busy_vsync", 64'(busy), 64'd1);
    at_neg(b + 14); chk("s1_busy_last_blank", 64'(busy), 64'd1);
    chk("s1_fc_before_done", 64'(frame_count), 64'd0);
    at_neg(b + 15); chk("s1_busy_after", 64'(busy), 64'd0);
    chk("s1_fc_after_done", 64'(frame_count), 64'd1);
    wait_drain();

    // Mid-line reset.
    goto(cyc + 2); b = cyc; start = 1'b1;
    push_ev(b + 3, K_VS, 0, 1'b0);
    for (int k = 0; k < 3; k++) push_ev(b + 5 + k, K_PIX, k + 1, 1'b0);
    goto(b + 1); start = 1'b0;
    goto(b + 7); reset = 1'b1;
    goto(b + 8); reset = 1'b0;
    at_neg(b + 8);
    chk_all_zero("after_reset");
    at_neg(b + 20);
    wait_drain();
    goto(b + 22); b2 = cyc; start = 1'b1; push_frame(b2 + 3, 0);
    goto(b2 + 1); start = 1'b0;
    at_neg(b2 + 15); chk("s2_fc_replay", 64'(frame_count), 64'd1);
    wait_drain();

    // Pause held across the first line boundary.
    goto(cyc + 2); b = cyc; start = 1'b1; push_frame(b + 3, 13);
    goto(b + 1); start = 1'b0;
    goto(b + 4); pause = 1'b1;
    at_neg(b + 15); chk("s3_busy_hold", 64'(busy), 64'd1);
    goto(b + 21); pause = 1'b0;
    at_neg(b + 27); chk("s3_fc_before_done", 64'(frame_count), 64'd1);
    at_neg(b + 28); chk("s3_fc_after_done", 64'(frame_count), 64'd2);
    wait_drain();

    // Continuous: two back-to-back frames.
    goto(cyc + 2); b = cyc; start = 1'b1; continuous = 1'b1;
    push_frame(b + 3, 0); push_frame(b + 17, 0);
    goto(b + 1); start = 1'b0;
    at_neg(b + 15); chk("s4_fc_frame1", 64'(frame_count), 64'd3);
    at_neg(b + 16); chk("s4_busy_between", 64'(busy), 64'd1);
    goto(b + 20); continuous = 1'b0;
    at_neg(b + 29); chk("s4_fc_frame2", 64'(frame_count), 64'd4);
    chk("s4_busy_after", 64'(busy), 64'd0);
    wait_drain();

    // Start held high through a whole frame, then a fresh start from idle.
    goto(cyc + 2); b = cyc; start = 1'b1; push_frame(b + 3, 0);
    goto(b + 15); start = 1'b0;
    at_neg(b + 15); chk("s5_busy_after", 64'(busy), 64'd0);
    chk("s5_fc", 64'(frame_count), 64'd5);
    goto(b + 20); b2 = cyc; start = 1'b1; push_frame(b2 + 3, 0);
    goto(b2 + 1); start = 1'b0;
    at_neg(b2 + 15); chk("s5_fc_fresh", 64'(frame_count), 64'd6);
    wait_drain();

    // Frame counter wrap; pause during the last line is not honoured.
    goto(cyc + 2);
    force dut.frame_count_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.frame_count_q;
    @(negedge clk); chk("s6_fc_preload", 64'(frame_count), 64'hFFFF_FFFF);
    goto(cyc + 2); b = cyc; start = 1'b1; push_frame(b + 3, 0);
    goto(b + 1); start = 1'b0;
    goto(b + 10); pause = 1'b1;
    at_neg(b + 14); chk("s6_fc_before_wrap", 64'(frame_count), 64'hFFFF_FFFF);
    at_neg(b + 15); chk("s6_fc_wrapped", 64'(frame_count), 64'd0);
    chk("s6_busy_after", 64'(busy), 64'd0);
    goto(b + 17); pause = 1'b0;
    wait_drain();

    at_neg(cyc + 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
